// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snooping-coherence bus: FSM states, the memory
// source code and the command/address split of a bus message.
package snoop_bus_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } bus_state_e;

    // Default 9-bit message: 3-bit command above a 6-bit address.
    localparam int unsigned MSG_CMD_W  = 3;
    localparam int unsigned MSG_ADDR_W = 6;

    // bus_src value that identifies the memory controller.
    function automatic int unsigned mem_src_code(input int unsigned n_proc);
        return n_proc;
    endfunction

    function automatic logic [MSG_CMD_W-1:0] msg_cmd(
        input logic [MSG_CMD_W+MSG_ADDR_W-1:0] m
    );
        return m[MSG_CMD_W+MSG_ADDR_W-1 -: MSG_CMD_W];
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Request/grant and broadcast signals between the cache controllers, memory
// and the snoop bus arbiter.
interface snoop_bus_arbiter_if #(
    parameter int unsigned N_PROC = 3,
    parameter int unsigned MSG_W  = 9,
    parameter int unsigned SRC_W  = $clog2(N_PROC + 1)
);
    logic [N_PROC-1:0]       req;
    logic [N_PROC-1:0]       lock;
    logic [N_PROC*MSG_W-1:0] msg;
    logic                    mem_valid;
    logic [MSG_W-1:0]        mem_msg;
    logic [N_PROC-1:0]       gnt;
    logic [MSG_W-1:0]        bus_out;
    logic                    bus_valid;
    logic [SRC_W-1:0]        bus_src;

    modport master (
        output req, lock, msg, mem_valid, mem_msg,
        input  gnt, bus_out, bus_valid, bus_src
    );

    modport slave (
        input  req, lock, msg, mem_valid, mem_msg,
        output gnt, bus_out, bus_valid, bus_src
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-hot pick: first set request at or above start, wrapping.
// With start tied to zero this is plain lowest-index-wins priority.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);
    int unsigned cand;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(start) + i) % N;
            if (!gnt_any && req[IDX_W'(cand)]) begin
                gnt_oh[IDX_W'(cand)] = 1'b1;
                gnt_idx              = IDX_W'(cand);
                gnt_any              = 1'b1;
            end
        end
    end
endmodule

// File: rtl/snoop_bus_arbiter.sv
// Registered snoop bus: memory > locked owner > arbitrated processors.
// Define SNOOP_BUS_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int unsigned N_PROC   = 3,
    parameter int unsigned MSG_W    = 9,
    parameter int unsigned LOCK_MAX = 4,
    parameter int unsigned SRC_W    = $clog2(N_PROC + 1)
) (
    input logic                clock,
    input logic                reset,
    snoop_bus_arbiter_if.slave bus
);
    localparam int unsigned     IDX_W   = (N_PROC > 1) ? $clog2(N_PROC) : 1;
    localparam int unsigned     CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [SRC_W-1:0] MEM_SRC = SRC_W'(mem_src_code(N_PROC));

    bus_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_PROC-1:0] gnt_q, gnt_d;
    logic [MSG_W-1:0]  bus_out_q, bus_out_d;
    logic              bus_valid_q, bus_valid_d;
    logic [SRC_W-1:0]  bus_src_q, bus_src_d;

    logic [MSG_W-1:0]  msg_arr [N_PROC];
    logic [IDX_W-1:0]  arb_start;
    logic [N_PROC-1:0] arb_oh;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic              owner_beat;

    for (genvar g = 0; g < N_PROC; g++) begin : g_msg
        assign msg_arr[g] = bus.msg[g*MSG_W +: MSG_W];
    end

`ifdef SNOOP_BUS_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_PROC - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    assign arb_start = ptr_q;
`else
    assign arb_start = '0;
`endif

    rr_arbiter #(
        .N     (N_PROC),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (bus.req),
        .start   (arb_start),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign owner_beat = (state_q == LOCKED) && bus.req[owner_q];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        bus_out_d   = '0;
        bus_valid_d = 1'b0;
        bus_src_d   = '0;
`ifdef SNOOP_BUS_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        if (bus.mem_valid) begin
            // Memory pre-empts everything and leaves any lock untouched.
            bus_valid_d = 1'b1;
            bus_out_d   = bus.mem_msg;
            bus_src_d   = MEM_SRC;
        end else if (owner_beat) begin
            gnt_d[owner_q] = 1'b1;
            bus_valid_d    = 1'b1;
            bus_out_d      = msg_arr[owner_q];
            bus_src_d      = SRC_W'(owner_q);
`ifdef SNOOP_BUS_ROUND_ROBIN_EN
            ptr_d          = next_idx(owner_q);
`endif
            // Release on the beat that brings the count up to LOCK_MAX.
            if (bus.lock[owner_q] && (32'(cnt_q) + 1 < LOCK_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                state_d = ARB;
                cnt_d   = '0;
            end
        end else begin
            // Owner dropping req releases the lock and arbitrates on this edge.
            if (state_q == LOCKED) begin
                state_d = ARB;
                cnt_d   = '0;
            end
            if (arb_any) begin
                gnt_d       = arb_oh;
                bus_valid_d = 1'b1;
                bus_out_d   = msg_arr[arb_idx];
                bus_src_d   = SRC_W'(arb_idx);
`ifdef SNOOP_BUS_ROUND_ROBIN_EN
                ptr_d       = next_idx(arb_idx);
`endif
                if (bus.lock[arb_idx] && (LOCK_MAX > 1)) begin
                    state_d = LOCKED;
                    owner_d = arb_idx;
                    cnt_d   = CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARB;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            bus_src_q   <= '0;
`ifdef SNOOP_BUS_ROUND_ROBIN_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            bus_src_q   <= bus_src_d;
`ifdef SNOOP_BUS_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.bus_out   = bus_out_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_src   = bus_src_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed self-checking bench for snoop_bus_arbiter (N_PROC=3, MSG_W=9,
// LOCK_MAX=4); expectations follow SNOOP_BUS_ROUND_ROBIN_EN when defined.
module tb_snoop_bus_arbiter;

`ifdef SNOOP_BUS_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [8:0] M0 = 9'h011;
    localparam logic [8:0] M1 = 9'h022;
    localparam logic [8:0] M2 = 9'h033;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [8:0] pm [3];

    snoop_bus_arbiter_if #(.N_PROC(3), .MSG_W(9), .SRC_W(2)) bus_if ();

    snoop_bus_arbiter #(
        .N_PROC   (3),
        .MSG_W    (9),
        .LOCK_MAX (4),
        .SRC_W    (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus_if.req       = '0;
        bus_if.lock      = '0;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_msg   = '0;
        bus_if.msg       = {M2, M1, M0};
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus_if.req       = 3'b111;
        bus_if.lock      = '0;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_msg   = '0;
        bus_if.msg       = {M2, M1, M0};
        tick();
        tick();
        checks += 4;
        if (bus_if.gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", bus_if.gnt); end
        if (bus_if.bus_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_if.bus_valid); end
        if (bus_if.bus_out !== 9'h000) begin failures++; $display("FAIL reset_out got=%h exp=000", bus_if.bus_out); end
        if (bus_if.bus_src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", bus_if.bus_src); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int w;
            w = RR ? i : 0;
            tick();
            checks += 3;
            if (bus_if.gnt !== 3'(1 << w)) begin failures++; $display("FAIL post_reset_gnt[%0d] got=%b exp=%b", i, bus_if.gnt, 3'(1 << w)); end
            if (bus_if.bus_src !== 2'(w)) begin failures++; $display("FAIL post_reset_src[%0d] got=%0d exp=%0d", i, bus_if.bus_src, w); end
            if (bus_if.bus_out !== pm[w] || bus_if.bus_valid !== 1'b1) begin failures++; $display("FAIL post_reset_out[%0d] got=%h/%b exp=%h/1", i, bus_if.bus_out, bus_if.bus_valid, pm[w]); end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        bus_if.req = 3'b101;
        for (int i = 0; i < 4; i++) begin
            int w;
            w = RR ? ((i % 2 == 0) ? 0 : 2) : 0;
            tick();
            checks += 2;
            if (bus_if.gnt !== 3'(1 << w)) begin failures++; $display("FAIL alternate_gnt[%0d] got=%b exp=%b", i, bus_if.gnt, 3'(1 << w)); end
            if (bus_if.bus_out !== pm[w]) begin failures++; $display("FAIL alternate_out[%0d] got=%h exp=%h", i, bus_if.bus_out, pm[w]); end
        end
        bus_if.req = '0;
    endtask

    task automatic test_mem_priority();
        do_reset();
        bus_if.req       = 3'b010;
        bus_if.mem_valid = 1'b1;
        bus_if.mem_msg   = 9'h1A5;
        tick();
        bus_if.mem_valid = 1'b0;
        checks += 4;
        if (bus_if.bus_src !== 2'd3) begin failures++; $display("FAIL mem_src got=%0d exp=3", bus_if.bus_src); end
        if (bus_if.bus_out !== 9'h1A5) begin failures++; $display("FAIL mem_out got=%h exp=1a5", bus_if.bus_out); end
        if (bus_if.gnt !== 3'b000) begin failures++; $display("FAIL mem_gnt got=%b exp=000", bus_if.gnt); end
        if (bus_if.bus_valid !== 1'b1) begin failures++; $display("FAIL mem_valid got=%b exp=1", bus_if.bus_valid); end
        tick();
        checks += 2;
        if (bus_if.gnt !== 3'b010) begin failures++; $display("FAIL mem_then_p1_gnt got=%b exp=010", bus_if.gnt); end
        if (bus_if.bus_src !== 2'd1 || bus_if.bus_out !== M1) begin failures++; $display("FAIL mem_then_p1_src got=%0d/%h exp=1/%h", bus_if.bus_src, bus_if.bus_out, M1); end
        bus_if.req = '0;
    endtask

    task automatic test_lock();
        int exp_w [6];
        do_reset();
        exp_w = '{2, 2, 2, 2, 0, RR ? 2 : 0};
        bus_if.req  = 3'b100;
        bus_if.lock = 3'b100;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus_if.req = 3'b101;
            checks += 2;
            if (bus_if.gnt !== 3'(1 << exp_w[i])) begin failures++; $display("FAIL lock_gnt[%0d] got=%b exp=%b", i, bus_if.gnt, 3'(1 << exp_w[i])); end
            if (bus_if.bus_src !== 2'(exp_w[i])) begin failures++; $display("FAIL lock_src[%0d] got=%0d exp=%0d", i, bus_if.bus_src, exp_w[i]); end
        end
        bus_if.req  = '0;
        bus_if.lock = '0;
    endtask

    task automatic test_mem_in_lock();
        int exp_w [4];
        do_reset();
        exp_w = '{2, 2, 2, 0};
        bus_if.req  = 3'b100;
        bus_if.lock = 3'b100;
        tick();
        bus_if.mem_valid = 1'b1;
        bus_if.mem_msg   = 9'h0F0;
        tick();
        bus_if.mem_valid = 1'b0;
        bus_if.req       = 3'b101;
        checks += 2;
        if (bus_if.bus_src !== 2'd3 || bus_if.bus_out !== 9'h0F0) begin failures++; $display("FAIL mem_in_lock_src got=%0d/%h exp=3/0f0", bus_if.bus_src, bus_if.bus_out); end
        if (bus_if.gnt !== 3'b000) begin failures++; $display("FAIL mem_in_lock_gnt got=%b exp=000", bus_if.gnt); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus_if.gnt !== 3'(1 << exp_w[i])) begin failures++; $display("FAIL mem_in_lock_beat[%0d] got=%b exp=%b", i, bus_if.gnt, 3'(1 << exp_w[i])); end
        end
        bus_if.req  = '0;
        bus_if.lock = '0;
    endtask

    task automatic test_zero_msg();
        do_reset();
        bus_if.msg = {M2, 9'h000, M0};
        bus_if.req = 3'b010;
        tick();
        bus_if.req = '0;
        checks += 4;
        if (bus_if.gnt !== 3'b010) begin failures++; $display("FAIL zero_gnt got=%b exp=010", bus_if.gnt); end
        if (bus_if.bus_valid !== 1'b1) begin failures++; $display("FAIL zero_valid got=%b exp=1", bus_if.bus_valid); end
        if (bus_if.bus_out !== 9'h000) begin failures++; $display("FAIL zero_out got=%h exp=000", bus_if.bus_out); end
        if (bus_if.bus_src !== 2'd1) begin failures++; $display("FAIL zero_src got=%0d exp=1", bus_if.bus_src); end
        bus_if.msg = {M2, M1, M0};
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        bus_if.req  = 3'b010;
        bus_if.lock = 3'b010;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks += 4;
        if (bus_if.gnt !== 3'b000) begin failures++; $display("FAIL midlock_gnt got=%b exp=000", bus_if.gnt); end
        if (bus_if.bus_valid !== 1'b0) begin failures++; $display("FAIL midlock_valid got=%b exp=0", bus_if.bus_valid); end
        if (bus_if.bus_out !== 9'h000) begin failures++; $display("FAIL midlock_out got=%h exp=000", bus_if.bus_out); end
        if (bus_if.bus_src !== 2'd0) begin failures++; $display("FAIL midlock_src got=%0d exp=0", bus_if.bus_src); end
        reset       = 1'b0;
        bus_if.req  = 3'b111;
        bus_if.lock = 3'b000;
        tick();
        checks++;
        if (bus_if.gnt !== 3'b001) begin failures++; $display("FAIL after_midlock_gnt0 got=%b exp=001", bus_if.gnt); end
        tick();
        checks++;
        if (bus_if.gnt !== (RR ? 3'b010 : 3'b001)) begin failures++; $display("FAIL after_midlock_gnt1 got=%b exp=%b", bus_if.gnt, RR ? 3'b010 : 3'b001); end
        bus_if.req = '0;
    endtask

    initial begin
        pm[0] = M0;
        pm[1] = M1;
        pm[2] = M2;
        test_reset();
        test_alternate();
        test_mem_priority();
        test_lock();
        test_mem_in_lock();
        test_zero_msg();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Parametrised snooping-coherence bus: it arbitrates among `N_PROC` processor caches and the memory controller, and broadcasts the winning message to all snoopers on a registered bus. It replaces the fixed-priority, combinational, zero-means-idle bus with several additions:
- an explicit request/grant handshake;
- round-robin fairness;
- a bounded bus lock for multi-beat transactions;
- a valid flag, so an all-zero message is legal.

It sits between the per-processor cache controllers and the shared snoop input of every cache and of memory.

## Interface
- `N_PROC`, default 3: number of processor requesters, ≥1.
- `MSG_W`, default 9: message width in bits.
- `LOCK_MAX`, default 4: maximum consecutive locked beats per owner, ≥1.
- `SRC_W`, default $clog2(N_PROC+1): width of the source index.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in N_PROC: per-processor request.
- `lock` in N_PROC: keep bus ownership after this beat.
- `msg` in N_PROC*MSG_W: flattened messages; processor i occupies bits [i*MSG_W +: MSG_W].
- `mem_valid` in 1: memory has a response.
- `mem_msg` in MSG_W: memory response.
- `gnt` out N_PROC: one-hot; the message sampled at the previous edge was consumed.
- `bus_out` out MSG_W: broadcast message.
- `bus_valid` out 1: `bus_out` is valid this cycle.
- `bus_src` out SRC_W: winner index; the value N_PROC means memory.

## Operation
- Each edge selects at most one winner from the candidates sampled at that edge. The winner's message is registered onto `bus_out`, with `bus_valid`=1, `bus_src` and `gnt` updated at the same edge.
- Priority, highest first:
  1. `mem_valid`: memory always wins, including during a lock.
  2. In LOCKED state, the owner only, if `req[owner]`=1.
  3. In ARB state, processors via the arbitration policy (see Configuration).
- Memory grants drive `gnt`=0.
- No candidate: `bus_valid`=0, `bus_out`=0, `bus_src`=0, `gnt`=0.
- Handshake:
  - The requester holds `req`/`msg` stable until it sees `gnt[i]`=1.
  - A `req[i]` still high during the `gnt[i]` cycle is a new request carrying the new `msg`.
- FSM, with a beat counter `cnt`:
  - ARB → LOCKED when a processor wins with `lock[i]`=1; owner=i, `cnt`=1.
  - LOCKED stays LOCKED on an owner beat with `lock[owner]`=1 and `cnt`<LOCK_MAX; `cnt` increments.
  - LOCKED → ARB when the owner beat has `lock`=0, or `cnt` reaches LOCK_MAX (forced release), or the owner drops `req` (release with no beat; arbitration runs at that same edge).
  - A memory beat during LOCKED leaves the state, owner and `cnt` unchanged.
- Round-robin pointer `ptr`:
  - Updated only on processor grants: `ptr` = winner+1, wrapping at N_PROC to 0.
  - A forced release therefore passes priority past the owner.
- Reset:
  - Outputs: `gnt`=0, `bus_out`=0, `bus_valid`=0, `bus_src`=0.
  - Internal: state ARB, `ptr`=0, `cnt`=0.
  - Reset mid-lock abandons the lock; the beat in flight is not granted.

## Timing
- Latency: a request sampled at edge E produces `gnt`/`bus_out`/`bus_valid` during cycle E→E+1.
- Throughput: one message per cycle. Back-to-back grants to different masters are allowed.
- Sampling: `req`, `lock`, `msg`, `mem_valid` and `mem_msg` are sampled only at rising edges. No combinational input-to-output path exists.
- Duration: `gnt` is high for exactly one cycle per consumed message.
- Simultaneous `mem_valid` and a processor request: memory wins. The processor stays pending, and `ptr` is unchanged.

## Configuration
- `SNOOP_BUS_ROUND_ROBIN_EN` defined: processor arbitration is round-robin, searching from `ptr` upward with wrap.
- Not defined: fixed priority, lowest index wins (legacy order). `ptr` is not implemented, and all other behaviour is identical.

## Structure
- Package/header `snoop_bus_pkg`:
  - the `bus_src` memory code (= N_PROC);
  - the FSM state encodings ARB/LOCKED;
  - the message field constants (command/address split of the MSG_W word) shared with the cache controllers.
- Sub-module `rr_arbiter`: an N-wide one-hot pick given a request vector and a start pointer (start fixed at 0 when round-robin is disabled). The top level holds the FSM, the lock counter and the output registers.

## Test plan
- Reset with all `req`=3'b111 held high: all outputs are 0 during reset. In the first cycle after reset, with round-robin, `gnt`=001 and `bus_src`=0; then 010 and 100 follow on successive cycles.
- `req`=3'b101 held continuously (round-robin on): grants alternate 001, 100, 001, 100. Without the macro, `gnt`=001 every cycle.
- `mem_valid`=1 with `mem_msg`=9'h1A5 while `req`=3'b010: `bus_src`=3, `bus_out`=9'h1A5 and `gnt`=0 for that cycle. P1 is granted the next cycle.
- P2 asserts `req` and `lock` for 6 beats, while P0 also requests (LOCK_MAX=4): P2 gets 4 consecutive grants, then P0 is granted, then P2.
- P1 requests with `msg`=9'h000: `bus_valid`=1, `bus_out`=0 and `gnt`=010. A zero message is legal.
- `reset` asserted during a locked sequence: the next cycle shows all outputs 0. After release, arbitration restarts from `ptr`=0 in ARB state.
